// File: rtl/twiddle_butterfly.sv
// Radix-2 DIT butterfly y0=(a+bW)/2, y1=(a-bW)/2 with a 3-stage pipeline,
// round-half-up and saturation, plus frame index / last tagging on the output.
module twiddle_butterfly #(
   parameter int unsigned DW    = 16,
   parameter int unsigned WW    = 16,
   parameter int unsigned WFRAC = 14,
   parameter int unsigned PAIRS = 4,
   localparam int unsigned IW   = (PAIRS > 1) ? $clog2(PAIRS) : 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   input  logic signed [DW-1:0] a_real,
   input  logic signed [DW-1:0] a_imag,
   input  logic signed [DW-1:0] b_real,
   input  logic signed [DW-1:0] b_imag,
   input  logic signed [WW-1:0] W_real,
   input  logic signed [WW-1:0] W_imag,
   output logic                 out_valid,
   output logic signed [DW-1:0] y0_real,
   output logic signed [DW-1:0] y0_imag,
   output logic signed [DW-1:0] y1_real,
   output logic signed [DW-1:0] y1_imag,
   output logic [IW-1:0]        out_index,
   output logic                 out_last,
   output logic                 sat_flag
);

   localparam int unsigned PW = DW + WW;
   localparam logic signed [PW:0] Rnd =
      {{(PW - WFRAC + 1){1'b0}}, 1'b1, {(WFRAC - 1){1'b0}}};
   localparam logic signed [DW-1:0] YMax = {1'b0, {(DW - 1){1'b1}}};
   localparam logic signed [DW-1:0] YMin = {1'b1, {(DW - 1){1'b0}}};
   localparam logic [IW-1:0] LastIdx = IW'(PAIRS - 1);

   // Returns {saturated, y} for y = sat((a +/- t + 1) >>> 1).
   function automatic logic [DW:0] round_sat(input logic signed [DW-1:0] a,
                                             input logic signed [DW:0]   t,
                                             input logic                 sub);
      logic signed [DW+1:0] s;
      logic signed [DW+1:0] h;
      s = sub ? ((DW + 2)'(a) - (DW + 2)'(t)) : ((DW + 2)'(a) + (DW + 2)'(t));
      h = (s + (DW + 2)'(1)) >>> 1;
      if (h[DW+1:DW-1] == 3'b000 || h[DW+1:DW-1] == 3'b111) begin
         return {1'b0, h[DW-1:0]};
      end
      return {1'b1, h[DW+1] ? YMin : YMax};
   endfunction

   // Stage 1
   logic                 v1_q;
   logic signed [PW-1:0] p_rr_q, p_ii_q, p_ri_q, p_ir_q;
   logic signed [DW-1:0] a1_re_q, a1_im_q;
   // Stage 2
   logic                 v2_q;
   logic signed [DW:0]   t_re_q, t_im_q;
   logic signed [DW-1:0] a2_re_q, a2_im_q;
   // Stage 3 / outputs
   logic                 out_valid_q;
   logic signed [DW-1:0] y0_re_q, y0_im_q, y1_re_q, y1_im_q;
   logic [IW-1:0]        out_index_q;
   logic                 sat_hit_q;
   logic                 sat_flag_q;

   logic signed [PW:0]   pr_sum, pi_sum;
   logic signed [DW:0]   t_re_d, t_im_d;
   logic [DW:0]          r0_re, r0_im, r1_re, r1_im;
   logic                 sat_any;

   always_comb begin
      pr_sum  = (PW + 1)'(p_rr_q) - (PW + 1)'(p_ii_q) + Rnd;
      pi_sum  = (PW + 1)'(p_ri_q) + (PW + 1)'(p_ir_q) + Rnd;
      // Twiddles lie on the unit circle, so t always fits DW+1 bits.
      t_re_d  = (DW + 1)'(pr_sum >>> WFRAC);
      t_im_d  = (DW + 1)'(pi_sum >>> WFRAC);
      r0_re   = round_sat(a2_re_q, t_re_q, 1'b0);
      r0_im   = round_sat(a2_im_q, t_im_q, 1'b0);
      r1_re   = round_sat(a2_re_q, t_re_q, 1'b1);
      r1_im   = round_sat(a2_im_q, t_im_q, 1'b1);
      sat_any = r0_re[DW] | r0_im[DW] | r1_re[DW] | r1_im[DW];
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         v1_q        <= 1'b0;
         p_rr_q      <= '0;
         p_ii_q      <= '0;
         p_ri_q      <= '0;
         p_ir_q      <= '0;
         a1_re_q     <= '0;
         a1_im_q     <= '0;
         v2_q        <= 1'b0;
         t_re_q      <= '0;
         t_im_q      <= '0;
         a2_re_q     <= '0;
         a2_im_q     <= '0;
         out_valid_q <= 1'b0;
         y0_re_q     <= '0;
         y0_im_q     <= '0;
         y1_re_q     <= '0;
         y1_im_q     <= '0;
         out_index_q <= '0;
         sat_hit_q   <= 1'b0;
         sat_flag_q  <= 1'b0;
      end else begin
         v1_q <= in_valid;
         if (in_valid) begin
            p_rr_q  <= PW'(b_real) * PW'(W_real);
            p_ii_q  <= PW'(b_imag) * PW'(W_imag);
            p_ri_q  <= PW'(b_real) * PW'(W_imag);
            p_ir_q  <= PW'(b_imag) * PW'(W_real);
            a1_re_q <= a_real;
            a1_im_q <= a_imag;
         end

         v2_q <= v1_q;
         if (v1_q) begin
            t_re_q  <= t_re_d;
            t_im_q  <= t_im_d;
            a2_re_q <= a1_re_q;
            a2_im_q <= a1_im_q;
         end

         out_valid_q <= v2_q;
         if (v2_q) begin
            y0_re_q <= r0_re[DW-1:0];
            y0_im_q <= r0_im[DW-1:0];
            y1_re_q <= r1_re[DW-1:0];
            y1_im_q <= r1_im[DW-1:0];
         end
         sat_hit_q  <= v2_q & sat_any;
         sat_flag_q <= sat_flag_q | sat_hit_q;

         if (out_valid_q) begin
            out_index_q <= (out_index_q == LastIdx) ? '0 : out_index_q + IW'(1);
         end
      end
   end

   assign out_valid = out_valid_q;
   assign y0_real   = y0_re_q;
   assign y0_imag   = y0_im_q;
   assign y1_real   = y1_re_q;
   assign y1_imag   = y1_im_q;
   assign out_index = out_index_q;
   assign out_last  = out_valid_q && (out_index_q == LastIdx);
   assign sat_flag  = sat_flag_q;

endmodule

// File: tb/tb_twiddle_butterfly.sv
// Directed and seeded-random checks of twiddle_butterfly: arithmetic, rounding,
// saturation, latency, frame indexing and mid-flight reset.
module tb_twiddle_butterfly;

   logic               clk = 1'b0;
   logic               rst_n;
   logic               in_valid;
   logic signed [15:0] a_real, a_imag, b_real, b_imag, W_real, W_imag;
   logic               out_valid, out_last, sat_flag;
   logic signed [15:0] y0_real, y0_imag, y1_real, y1_imag;
   logic [1:0]         out_index;

   always #5 clk = ~clk;

   twiddle_butterfly #(.DW(16), .WW(16), .WFRAC(14), .PAIRS(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .a_real    (a_real),
      .a_imag    (a_imag),
      .b_real    (b_real),
      .b_imag    (b_imag),
      .W_real    (W_real),
      .W_imag    (W_imag),
      .out_valid (out_valid),
      .y0_real   (y0_real),
      .y0_imag   (y0_imag),
      .y1_real   (y1_real),
      .y1_imag   (y1_imag),
      .out_index (out_index),
      .out_last  (out_last),
      .sat_flag  (sat_flag)
   );

   int total = 0;
   int bad   = 0;

   int vin[32], ar[32], ai[32], br[32], bi[32], wr[32], wi[32];
   int e0r[32], e0i[32], e1r[32], e1i[32], esat[32];
   int exp_idx, exp_sat, last_y0r;

   int tw_r[9] = '{16384, 11585, 0, -11585, -16384, -11585, 0, 11585, 0};
   int tw_i[9] = '{0, -11585, -16384, -11585, 0, 11585, 16384, 11585, 0};

   task automatic check_eq(input string tag, input longint got, input longint exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic set_vec(input int k, input int v, input int xar, input int xai,
                          input int xbr, input int xbi, input int xwr, input int xwi,
                          input int x0r, input int x0i, input int x1r, input int x1i,
                          input int xs);
      vin[k] = v;  ar[k] = xar; ai[k] = xai; br[k] = xbr; bi[k] = xbi;
      wr[k] = xwr; wi[k] = xwi;
      e0r[k] = x0r; e0i[k] = x0i; e1r[k] = x1r; e1i[k] = x1i; esat[k] = xs;
   endtask

   function automatic int half_sat(input longint s, inout int f);
      longint y;
      y = (s + 1) >>> 1;
      if (y > 32767) begin
         f = 1;
         return 32767;
      end
      if (y < -32768) begin
         f = 1;
         return -32768;
      end
      return int'(y);
   endfunction

   task automatic model_vec(input int k, input int v, input int xar, input int xai,
                            input int xbr, input int xbi, input int xwr, input int xwi);
      longint tr, ti;
      int     f;
      f  = 0;
      tr = (longint'(xbr) * xwr - longint'(xbi) * xwi + 8192) >>> 14;
      ti = (longint'(xbr) * xwi + longint'(xbi) * xwr + 8192) >>> 14;
      set_vec(k, v, xar, xai, xbr, xbi, xwr, xwi,
              half_sat(longint'(xar) + tr, f), half_sat(longint'(xai) + ti, f),
              half_sat(longint'(xar) - tr, f), half_sat(longint'(xai) - ti, f), 0);
      esat[k] = (v != 0) ? f : 0;
   endtask

   task automatic drive(input int k);
      in_valid = (vin[k] != 0);
      a_real = 16'(ar[k]); a_imag = 16'(ai[k]);
      b_real = 16'(br[k]); b_imag = 16'(bi[k]);
      W_real = 16'(wr[k]); W_imag = 16'(wi[k]);
   endtask

   // Entered and left on a falling edge; output for slot j is due three cycles later.
   task automatic run_stream(input int n);
      int j;
      for (int c = 0; c < n + 3; c++) begin
         if (c >= 3) begin
            j = c - 3;
            check_eq($sformatf("v%0d.out_valid", j), out_valid, vin[j] != 0);
            check_eq($sformatf("v%0d.sat_flag", j), sat_flag, exp_sat);
            if (vin[j] != 0) begin
               check_eq($sformatf("v%0d.y0_real", j), y0_real, e0r[j]);
               check_eq($sformatf("v%0d.y0_imag", j), y0_imag, e0i[j]);
               check_eq($sformatf("v%0d.y1_real", j), y1_real, e1r[j]);
               check_eq($sformatf("v%0d.y1_imag", j), y1_imag, e1i[j]);
               check_eq($sformatf("v%0d.out_index", j), out_index, exp_idx);
               check_eq($sformatf("v%0d.out_last", j), out_last, exp_idx == 3);
               last_y0r = e0r[j];
               if (esat[j] != 0) exp_sat = 1;
               exp_idx = (exp_idx + 1) % 4;
            end else begin
               check_eq($sformatf("v%0d.bubble_last", j), out_last, 0);
               check_eq($sformatf("v%0d.hold_y0r", j), y0_real, last_y0r);
            end
         end
         if (c < n) drive(c);
         else in_valid = 1'b0;
         @(negedge clk);
      end
   endtask

   initial begin
      rst_n = 1'b0; in_valid = 1'b0;
      a_real = '0; a_imag = '0; b_real = '0; b_imag = '0; W_real = '0; W_imag = '0;
      repeat (2) @(negedge clk);
      check_eq("rst.out_valid", out_valid, 0);
      check_eq("rst.out_last", out_last, 0);
      check_eq("rst.sat_flag", sat_flag, 0);
      check_eq("rst.out_index", out_index, 0);
      check_eq("rst.y0_real", y0_real, 0);
      check_eq("rst.y0_imag", y0_imag, 0);
      check_eq("rst.y1_real", y1_real, 0);
      check_eq("rst.y1_imag", y1_imag, 0);
      rst_n = 1'b1;
      exp_idx = 0; exp_sat = 0; last_y0r = 0;

      // Unit twiddle, -j twiddle, zero twiddle, positive saturation; index 0..3.
      set_vec(0, 1, 1000, 0, 200, 0, 16384, 0, 600, 0, 400, 0, 0);
      set_vec(1, 1, 0, 0, 100, 0, 0, -16384, 0, -50, 0, 50, 0);
      set_vec(2, 1, -3, 5, 7, 7, 0, 0, -1, 3, -1, 3, 0);
      set_vec(3, 1, 0, 32767, 32767, 32767, 11585, 11585, 0, 32767, 0, -6786, 1);
      run_stream(4);
      check_eq("sat_one_edge_after", sat_flag, 1);

      // Clean input keeps the sticky flag; then negative saturation.
      set_vec(0, 1, 1000, 0, 200, 0, 16384, 0, 600, 0, 400, 0, 0);
      set_vec(1, 1, 0, -32768, 32767, 32767, 11585, 11585, 0, 6786, 0, -32768, 1);
      run_stream(2);
      check_eq("sat_sticky", sat_flag, 1);

      // Reset while three inputs are in flight.
      set_vec(0, 1, 1000, 0, 200, 0, 16384, 0, 600, 0, 400, 0, 0);
      drive(0); @(negedge clk);
      drive(0); @(negedge clk);
      drive(0); rst_n = 1'b0; @(negedge clk);
      check_eq("midrst.out_valid", out_valid, 0);
      check_eq("midrst.sat_flag", sat_flag, 0);
      check_eq("midrst.out_index", out_index, 0);
      check_eq("midrst.y0_real", y0_real, 0);
      rst_n = 1'b1; in_valid = 1'b0;
      exp_idx = 0; exp_sat = 0; last_y0r = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check_eq($sformatf("midrst.stale%0d", i), out_valid, 0);
      end

      // Bubbles after the 2nd input; the 5th wraps to index 0.
      set_vec(0, 1, 0, 0, 1234, -999, 0, 0, 0, 0, 0, 0, 0);
      set_vec(1, 1, 2, -2, 1234, -999, 0, 0, 1, -1, 1, -1, 0);
      set_vec(2, 0, 5555, 5555, 77, 77, 16384, 0, 0, 0, 0, 0, 0);
      set_vec(3, 0, -5555, 5555, 77, 77, 16384, 0, 0, 0, 0, 0, 0);
      set_vec(4, 1, 4, -4, 1234, -999, 0, 0, 2, -2, 2, -2, 0);
      set_vec(5, 1, 6, -6, 1234, -999, 0, 0, 3, -3, 3, -3, 0);
      set_vec(6, 1, 8, -8, 1234, -999, 0, 0, 4, -4, 4, -4, 0);
      run_stream(7);

      // Seeded random vectors on the twiddle circle against the reference model.
      for (int k = 0; k < 24; k++) begin
         int t;
         t = $urandom_range(0, 8);
         model_vec(k, ($urandom_range(0, 4) != 0) ? 1 : 0,
                   int'($urandom_range(0, 65535)) - 32768, int'($urandom_range(0, 65535)) - 32768,
                   int'($urandom_range(0, 65535)) - 32768, int'($urandom_range(0, 65535)) - 32768,
                   tw_r[t], tw_i[t]);
      end
      run_stream(24);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
